// File: rtl/freq_sel_gen_if.sv
// Control/status bundle for freq_sel_gen: switch inputs in, square wave and status out.
interface freq_sel_gen_if;
  logic       en;
  logic [1:0] sel;
  logic       outfreq;
  logic       tick;
  logic [1:0] cur_sel;
  logic       pending;

  modport master (output en, sel, input outfreq, tick, cur_sel, pending);
  modport slave  (input en, sel, output outfreq, tick, cur_sel, pending);
endinterface

// File: rtl/freq_sel_gen.sv
// Glitch-free four-rate square-wave generator; rate/enable changes land only on period boundaries.
module freq_sel_gen #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int RATE0_HZ = 1,
  parameter int RATE1_HZ = 2,
  parameter int RATE2_HZ = 5,
  parameter int RATE3_HZ = 10,
  parameter int CNT_W    = 26
) (
  input logic           clkfreq,
  input logic           rst_n,
  freq_sel_gen_if.slave bus
);

  function automatic logic [CNT_W-1:0] half_of(input int rate);
    int h;
    h = CLK_HZ / (2 * rate);
    if (h < 1) h = 1;
    return CNT_W'(h);
  endfunction

  localparam logic [3:0][CNT_W-1:0] HALF = {half_of(RATE3_HZ), half_of(RATE2_HZ),
                                            half_of(RATE1_HZ), half_of(RATE0_HZ)};

  typedef enum logic [1:0] {IDLE, HI, LO} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             en_meta, en_s;
  logic [1:0]       sel_meta, sel_s;
  logic             outfreq_q, tick_q;
  logic [1:0]       cur_sel_q;
  logic             last;

  // Switches are asynchronous to clkfreq: two flops before the FSM sees them.
  always_ff @(posedge clkfreq or negedge rst_n) begin
    if (!rst_n) begin
      en_meta  <= 1'b0;
      en_s     <= 1'b0;
      sel_meta <= 2'd0;
      sel_s    <= 2'd0;
    end else begin
      en_meta  <= bus.en;
      en_s     <= en_meta;
      sel_meta <= bus.sel;
      sel_s    <= sel_meta;
    end
  end

  assign last = (cnt == HALF[cur_sel_q] - CNT_W'(1));

  always_ff @(posedge clkfreq or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      outfreq_q <= 1'b0;
      tick_q    <= 1'b0;
      cur_sel_q <= 2'd0;
    end else begin
      tick_q <= 1'b0;
      case (state)
        IDLE: begin
          outfreq_q <= 1'b0;
          cnt       <= '0;
          if (en_s) begin
            cur_sel_q <= sel_s;
            outfreq_q <= 1'b1;
            tick_q    <= 1'b1;
            state     <= HI;
          end
        end
        HI: begin
          if (last) begin
            outfreq_q <= 1'b0;
            cnt       <= '0;
            state     <= LO;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        LO: begin
          if (last) begin
            cnt <= '0;
            // Disable wins over a simultaneous rate change at the period end.
            if (!en_s) begin
              state <= IDLE;
            end else begin
              cur_sel_q <= sel_s;
              outfreq_q <= 1'b1;
              tick_q    <= 1'b1;
              state     <= HI;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          outfreq_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.outfreq = outfreq_q;
  assign bus.tick    = tick_q;
  assign bus.cur_sel = cur_sel_q;
  // Decoded purely from registers, so no input reaches it combinationally.
  assign bus.pending = (state != IDLE) && (sel_s != cur_sel_q);

endmodule

// File: tb/tb_freq_sel_gen.sv
// Randomised + directed bench for freq_sel_gen against a period-position reference model.
module tb_freq_sel_gen;

  logic clkfreq = 1'b0;
  logic rst_n   = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;
  bit   chk_on  = 1'b0;

  freq_sel_gen_if bus ();

  freq_sel_gen #(
    .CLK_HZ(100), .RATE0_HZ(5), .RATE1_HZ(10), .RATE2_HZ(25), .RATE3_HZ(50), .CNT_W(8)
  ) dut (
    .clkfreq(clkfreq),
    .rst_n  (rst_n),
    .bus    (bus.slave)
  );

  always #5 clkfreq = ~clkfreq;

  // Reference: the generator is "running" with a position inside a 2*HALF period.
  function automatic int half_m(input logic [1:0] s);
    int rates [4] = '{5, 10, 25, 50};
    int h;
    h = 100 / (2 * rates[s]);
    return (h < 1) ? 1 : h;
  endfunction

  logic       m_em, m_es;
  logic [1:0] m_sm, m_ss, m_cur;
  logic       m_run;
  int         m_pos;

  always @(posedge clkfreq or negedge rst_n) begin
    if (!rst_n) begin
      m_em <= 0; m_es <= 0; m_sm <= 0; m_ss <= 0;
      m_run <= 0; m_cur <= 0; m_pos <= 0;
    end else begin
      if (!m_run) begin
        if (m_es) begin m_run <= 1; m_cur <= m_ss; m_pos <= 0; end
      end else if (m_pos == 2 * half_m(m_cur) - 1) begin
        if (m_es) begin m_cur <= m_ss; m_pos <= 0; end
        else begin m_run <= 0; m_pos <= 0; end
      end else begin
        m_pos <= m_pos + 1;
      end
      m_em <= bus.en;  m_es <= m_em;
      m_sm <= bus.sel; m_ss <= m_sm;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clkfreq) begin
    if (chk_on) begin
      chk("model_outfreq", int'(bus.outfreq), int'(m_run && m_pos < half_m(m_cur)));
      chk("model_tick",    int'(bus.tick),    int'(m_run && m_pos == 0));
      chk("model_cur_sel", int'(bus.cur_sel), int'(m_cur));
      chk("model_pending", int'(bus.pending), int'(m_run && m_ss != m_cur));
    end
  end

  task automatic wait_cond(input logic [1:0] v, input logic of, input int budget, input string nm);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clkfreq);
      if (bus.cur_sel == v && bus.outfreq == of) break;
    end
    n_cmp++;
    if (i == budget) begin
      n_bad++;
      $display("FAIL %s: timeout after %0d cycles waiting cur_sel=%0d outfreq=%0d", nm, budget, v, of);
    end
  endtask

  task automatic run_len(input logic v, output int n);
    n = 0;
    while (bus.outfreq == v && n < 50) begin
      n++;
      @(negedge clkfreq);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clkfreq);
  endtask

  initial begin
    int n;
    bus.en = 0; bus.sel = 0;
    cycles(2);
    rst_n = 1;
    chk_on = 1;
    @(negedge clkfreq);
    chk("rst_outfreq", int'(bus.outfreq), 0);
    chk("rst_tick",    int'(bus.tick),    0);
    chk("rst_cur_sel", int'(bus.cur_sel), 0);
    chk("rst_pending", int'(bus.pending), 0);

    // Start latency and 10/10 waveform at sel=0.
    bus.en = 1;
    cycles(2);
    chk("start_not_yet", int'(bus.outfreq), 0);
    @(negedge clkfreq);
    chk("start_outfreq", int'(bus.outfreq), 1);
    chk("start_tick",    int'(bus.tick),    1);
    run_len(1, n); chk("sel0_high", n, 10);
    run_len(0, n); chk("sel0_low",  n, 10);
    chk("sel0_tick2", int'(bus.tick), 1);

    // Rate change three clocks into HI.
    cycles(3);
    bus.sel = 1;
    cycles(2);
    chk("pending_set", int'(bus.pending), 1);
    n = 0;
    while (bus.outfreq != 0 && n < 20) begin n++; @(negedge clkfreq); end
    run_len(0, n); chk("old_period_low", n, 10);
    chk("sw_cur_sel", int'(bus.cur_sel), 1);
    chk("sw_pending", int'(bus.pending), 0);
    run_len(1, n); chk("sel1_high", n, 5);
    run_len(0, n); chk("sel1_low",  n, 5);

    // HALF=1: strict alternation.
    bus.sel = 3;
    wait_cond(3, 1, 40, "wait_sel3");
    for (int k = 0; k < 4; k++) begin
      chk("h1_outfreq", int'(bus.outfreq), (k % 2 == 0) ? 1 : 0);
      chk("h1_tick",    int'(bus.tick),    (k % 2 == 0) ? 1 : 0);
      @(negedge clkfreq);
    end

    // Disable mid-HI at sel=2, then restart.
    bus.sel = 2;
    wait_cond(2, 1, 40, "wait_sel2");
    @(negedge clkfreq);
    bus.en = 0;
    cycles(12);
    chk("idle_outfreq", int'(bus.outfreq), 0);
    chk("idle_pending", int'(bus.pending), 0);
    bus.en = 1;
    wait_cond(2, 1, 20, "restart");
    run_len(1, n); chk("restart_high", n, 2);

    // Several sel changes in one period: only the last survives.
    bus.sel = 0;
    wait_cond(0, 1, 40, "wait_sel0");
    @(negedge clkfreq); bus.sel = 2;
    cycles(3);          bus.sel = 1;
    wait_cond(1, 1, 40, "wait_sel1");
    run_len(1, n); chk("toggle_high", n, 5);

    // Async reset mid-LO at sel=2.
    bus.sel = 2;
    wait_cond(2, 0, 40, "wait_lo2");
    @(posedge clkfreq); #2;
    rst_n = 0;
    #1;
    chk("arst_outfreq", int'(bus.outfreq), 0);
    chk("arst_tick",    int'(bus.tick),    0);
    chk("arst_cur_sel", int'(bus.cur_sel), 0);
    chk("arst_pending", int'(bus.pending), 0);
    cycles(2);
    rst_n = 1;
    cycles(2);
    chk("rel_not_yet", int'(bus.outfreq), 0);
    @(negedge clkfreq);
    chk("rel_outfreq", int'(bus.outfreq), 1);
    chk("rel_cur_sel", int'(bus.cur_sel), 2);

    // Random switch activity; the model checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clkfreq);
      if ($urandom_range(0, 59) == 0) bus.en = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 14) == 0) bus.sel = 2'($urandom_range(0, 3));
    end

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/freq_sel_gen.md
# freq_sel_gen

Parametrised, glitch-free selectable-frequency square-wave generator for the Spartan-3E LED/switch designs. Divides `clkfreq` down to one of four compile-time rates chosen by a switch-driven select bus, with synchronised inputs, 50% duty, an enable, and rate changes applied only at period boundaries so `outfreq` never emits a runt pulse. It supersedes the fixed two-rate selector and drives LEDs or downstream blink/count logic directly.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, input clock frequency in Hz
- `RATE0_HZ`, 1, output rate for `sel`=0
- `RATE1_HZ`, 2, output rate for `sel`=1
- `RATE2_HZ`, 5, output rate for `sel`=2
- `RATE3_HZ`, 10, output rate for `sel`=3
- `CNT_W`, 26, half-period counter width; must hold `CLK_HZ/(2*RATEn_HZ)-1` for every n

Ports:
- `clkfreq`  in  1  system clock; one clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  run request; asynchronous (switch); synchronised internally
- `sel`  in  2  rate select; asynchronous (switches); synchronised internally
- `outfreq`  out  1  registered square wave
- `tick`  out  1  one-cycle pulse coincident with each rising edge of `outfreq`
- `cur_sel`  out  2  rate currently being generated
- `pending`  out  1  synchronised `sel` differs from `cur_sel`, change not yet applied

## Operation
- `en` and `sel` each pass through a 2-flop synchroniser (`en_s`, `sel_s`); reset value 0.
- `HALFn = CLK_HZ/(2*RATEn_HZ)`, integer floor, clamped to a minimum of 1. The active half-period is `HALF[cur_sel]`.
- FSM states: IDLE, HI, LO. Counter `cnt` is `CNT_W` bits.
  - IDLE: `outfreq`=0, `cnt`=0. If `en_s`=1: `cur_sel`<=`sel_s`, `outfreq`<=1, `tick`<=1, `cnt`<=0, go to HI.
  - HI: `cnt` increments. At `cnt`==HALF-1: `outfreq`<=0, `cnt`<=0, go to LO. `en_s` and `sel_s` are ignored here.
  - LO: `cnt` increments. At `cnt`==HALF-1 (period end): if `en_s`=0, go to IDLE; otherwise `cur_sel`<=`sel_s`, `outfreq`<=1, `tick`<=1, `cnt`<=0, go to HI.
- Every period is exactly HALF cycles high followed by HALF cycles low. Rate changes and disable take effect only at period end; a started period always completes.
- `pending` = (`sel_s` != `cur_sel`) while not IDLE; 0 in IDLE.
- `tick` is 1 only on the cycle `outfreq` first reads 1, and 0 otherwise.
- Several `sel` changes within one period: only the value of `sel_s` at period end is applied.
- `en` and `sel` changing together during LO: both are evaluated at the same period end, and disable takes priority.

## Timing
- Reset (async assert, any state, any time): `outfreq`=0, `tick`=0, `cur_sel`=0, `pending`=0, state IDLE, `cnt`=0, synchronisers cleared. Release is synchronous to `clkfreq`.
- Input latency: an `en` or `sel` change is visible to the FSM 2 clocks later (`en_s`/`sel_s`).
- Start latency: if `en` goes high at edge k (setup met), `en_s`=1 after edge k+2, and `outfreq`/`tick` go high at edge k+3.
- Period = 2*HALF clocks. HALF=1 gives `outfreq` toggling every clock with `tick` every 2 clocks.
- Rate-switch latency: at most 2 sync cycles plus the remainder of the current period.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
Sim parameters: `CLK_HZ`=100, rates 5/10/25/50, giving HALF=10/5/2/1.
- Reset then `en`=1, `sel`=0: `outfreq` rises 3 clocks after `en`, then runs 10 high/10 low repeatedly; `tick` pulses every 20 clocks; `cur_sel`=0; `pending`=0.
- Running `sel`=0, set `sel`=1 three clocks into HI: `pending`=1 within 2 clocks; the current period completes as 10/10; the next period is 5/5; `cur_sel`=1; `pending` clears on that rising edge.
- `sel`=3 (HALF=1): `outfreq` alternates 1,0 every clock and `tick` is 1 every other clock; no duty-cycle violation.
- `en`=0 mid-HI at `sel`=2: remaining HI cycles and 2 LO cycles complete, then IDLE with `outfreq` held 0; `en`=1 again restarts with a full HI period.
- `sel` toggled 0->2->1 within one period: only `sel`=1 is applied at period end; no pulse shorter than HALF appears.
- `rst_n` pulsed low mid-LO at `sel`=2: all outputs read 0 immediately (asynchronously); after release with `en`=1 held, normal start occurs 3 clocks later at `cur_sel`=2.
